// File: rtl/conv_mac_datapath_pkg.sv
// rtl/conv_mac_datapath_pkg.sv - shared sizes and types for the convolution MAC datapath
package conv_pkg;
  localparam int T                = 8;
  localparam int X_MEM_SIZE       = 8;
  localparam int F_MEM_SIZE       = 4;
  localparam int X_MEM_ADDR_WIDTH = 3;
  localparam int F_MEM_ADDR_WIDTH = 2;
  localparam int Y_WIDTH          = 18;

  typedef enum logic [1:0] {IDLE, CALC, OUT} conv_state_t;
  typedef logic signed [T-1:0] sample_t;
endpackage

// File: rtl/conv_mac_datapath_mem.sv
// rtl/conv_mac_datapath_mem.sv - single-port-write, registered-read memory
// Read is read-first: a same-edge write to the read address returns the old word.
module conv_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/conv_mac_datapath.sv
// rtl/conv_mac_datapath.sv - x/f sample memories and sequential MAC producing one y per request
module conv_mac_datapath
  import conv_pkg::*;
#(
  parameter int T_W          = conv_pkg::T,
  parameter int X_SIZE       = conv_pkg::X_MEM_SIZE,
  parameter int F_SIZE       = conv_pkg::F_MEM_SIZE,
  parameter int X_AW         = conv_pkg::X_MEM_ADDR_WIDTH,
  parameter int F_AW         = conv_pkg::F_MEM_ADDR_WIDTH,
  parameter int Y_W          = conv_pkg::Y_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic signed [T_W-1:0] s_data_in_x,
  input  logic                  x_wr_en,
  input  logic [X_AW-1:0]       x_wr_addr,
  input  logic signed [T_W-1:0] s_data_in_f,
  input  logic                  s_valid_f,
  output logic                  s_ready_f,
  input  logic                  f_clear,
  input  logic                  calc_start,
  input  logic [X_AW-1:0]       calc_base,
  output logic                  calc_busy,
  output logic signed [Y_W-1:0] m_data_out_y,
  output logic                  m_valid_y,
  input  logic                  m_ready_y
);
  localparam logic [F_AW:0] F_FULL = (F_AW+1)'(F_SIZE);
  localparam int EXT = Y_W - 2*T_W;

  conv_state_t           state_q;
  logic [F_AW:0]         f_count_q, f_count_d, cyc_q;
  logic                  f_loaded_q, s_ready_f_q, busy_q, m_valid_q, f_fire;
  logic [X_AW-1:0]       base_q, x_rd_addr;
  logic [F_AW-1:0]       f_rd_addr;
  logic signed [T_W-1:0] x_rd, f_rd;
  logic signed [2*T_W-1:0] prod;
  logic signed [Y_W-1:0] acc_q, acc_d, y_q;

  conv_mem #(.DEPTH(X_SIZE), .WIDTH(T_W), .AW(X_AW)) u_x_mem (
    .clk(clk), .wr_en(x_wr_en), .wr_addr(x_wr_addr), .wr_data(s_data_in_x),
    .rd_addr(x_rd_addr), .rd_data(x_rd)
  );

  conv_mem #(.DEPTH(F_SIZE), .WIDTH(T_W), .AW(F_AW)) u_f_mem (
    .clk(clk), .wr_en(f_fire), .wr_addr(f_count_q[F_AW-1:0]), .wr_data(s_data_in_f),
    .rd_addr(f_rd_addr), .rd_data(f_rd)
  );

  assign f_fire = s_valid_f && s_ready_f_q;

  // Read j is issued on CALC cycle j; its product lands in the accumulator one cycle later.
  always_comb begin
    f_rd_addr = cyc_q[F_AW-1:0];
    x_rd_addr = base_q + X_AW'(cyc_q[F_AW-1:0]);
    prod      = x_rd * f_rd;
    acc_d     = acc_q + $signed({{EXT{prod[2*T_W-1]}}, prod});
    f_count_d = f_count_q;
    if (state_q == IDLE && f_clear) f_count_d = '0;
    else if (f_fire)                f_count_d = f_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      f_count_q   <= '0;
      f_loaded_q  <= 1'b0;
      s_ready_f_q <= 1'b0;
      busy_q      <= 1'b0;
      m_valid_q   <= 1'b0;
      y_q         <= '0;
      acc_q       <= '0;
      cyc_q       <= '0;
      base_q      <= '0;
    end else begin
      f_count_q  <= f_count_d;
      f_loaded_q <= (f_count_d == F_FULL);
      case (state_q)
        IDLE: begin
          s_ready_f_q <= (f_count_d < F_FULL);
          if (calc_start && f_loaded_q) begin
            state_q     <= CALC;
            base_q      <= calc_base;
            cyc_q       <= '0;
            acc_q       <= '0;
            busy_q      <= 1'b1;
            s_ready_f_q <= 1'b0;
          end
        end
        CALC: begin
          s_ready_f_q <= 1'b0;
          cyc_q       <= cyc_q + 1'b1;
          if (cyc_q != '0) acc_q <= acc_d;
          if (cyc_q == F_FULL) begin
            state_q   <= OUT;
            m_valid_q <= 1'b1;
            y_q       <= acc_d;
          end
        end
        OUT: begin
          s_ready_f_q <= 1'b0;
          if (m_ready_y) begin
            state_q     <= IDLE;
            m_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
            s_ready_f_q <= (f_count_q < F_FULL);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready_f    = s_ready_f_q;
  assign calc_busy    = busy_q;
  assign m_valid_y    = m_valid_q;
  assign m_data_out_y = y_q;
endmodule

// File: tb/tb_conv_mac_datapath.sv
// tb/tb_conv_mac_datapath.sv - randomized and directed checks of conv_mac_datapath against an array model
module tb_conv_mac_datapath;
  import conv_pkg::*;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  sample_t             s_data_in_x = '0;
  logic                x_wr_en = 1'b0;
  logic [2:0]          x_wr_addr = '0;
  sample_t             s_data_in_f = '0;
  logic                s_valid_f = 1'b0;
  logic                s_ready_f;
  logic                f_clear = 1'b0;
  logic                calc_start = 1'b0;
  logic [2:0]          calc_base = '0;
  logic                calc_busy;
  logic signed [17:0]  m_data_out_y;
  logic                m_valid_y;
  logic                m_ready_y = 1'b1;

  int passed = 0;
  int total  = 0;
  int xm[8];
  int fm[4];
  int fidx = 0;

  conv_mac_datapath dut (
    .clk(clk), .reset(reset),
    .s_data_in_x(s_data_in_x), .x_wr_en(x_wr_en), .x_wr_addr(x_wr_addr),
    .s_data_in_f(s_data_in_f), .s_valid_f(s_valid_f), .s_ready_f(s_ready_f),
    .f_clear(f_clear), .calc_start(calc_start), .calc_base(calc_base),
    .calc_busy(calc_busy), .m_data_out_y(m_data_out_y), .m_valid_y(m_valid_y),
    .m_ready_y(m_ready_y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint want);
    total++;
    if (got == want) passed++;
    else $display("FAIL %s got=%0d expected=%0d", tag, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint model_y(input int base);
    longint s = 0;
    for (int j = 0; j < 4; j++) s += longint'(fm[j]) * longint'(xm[(base + j) % 8]);
    return s;
  endfunction

  task automatic write_x(input int addr, input int v);
    x_wr_addr = addr[2:0];
    s_data_in_x = v[7:0];
    x_wr_en = 1'b1;
    tick();
    x_wr_en = 1'b0;
    xm[addr] = v;
  endtask

  task automatic clear_f();
    f_clear = 1'b1;
    tick();
    f_clear = 1'b0;
    fidx = 0;
  endtask

  task automatic push_f(input int v);
    int waited = 0;
    s_data_in_f = v[7:0];
    s_valid_f = 1'b1;
    while (!s_ready_f && waited < 20) begin
      tick();
      waited++;
    end
    if (waited == 20) check("f_ready_timeout", 0, 1);
    tick();
    s_valid_f = 1'b0;
    fm[fidx % 4] = v;
    fidx++;
  endtask

  task automatic load_f(input int a, input int b, input int c, input int d);
    clear_f();
    push_f(a); push_f(b); push_f(c); push_f(d);
  endtask

  task automatic run_calc(input int base, output longint y, output int lat);
    int n = 0;
    calc_base = base[2:0];
    calc_start = 1'b1;
    tick();
    calc_start = 1'b0;
    while (!m_valid_y && n < 40) begin
      tick();
      n++;
    end
    if (n == 40) check("valid_timeout", 0, 1);
    lat = n + 1;
    y = longint'(m_data_out_y);
  endtask

  task automatic full_calc(input string tag, input int base);
    longint y;
    int lat;
    run_calc(base, y, lat);
    check({tag, "_y"}, y, model_y(base));
    check({tag, "_lat"}, lat, 6);
    tick();
    check({tag, "_done"}, {m_valid_y, calc_busy}, 0);
  endtask

  initial begin
    longint y;
    int lat;
    int seen;

    tick(); tick();
    check("rst_ready", s_ready_f, 0);
    check("rst_busy", calc_busy, 0);
    check("rst_valid", m_valid_y, 0);
    check("rst_y", m_data_out_y, 0);
    reset = 1'b0;
    tick();
    check("ready_after_rst", s_ready_f, 1);

    load_f(1, 2, 3, 4);
    for (int i = 0; i < 8; i++) write_x(i, i + 1);
    run_calc(0, y, lat);
    check("y_base0", y, 30);
    check("lat_base0", lat, 6);
    tick();
    check("hs_base0", {m_valid_y, calc_busy}, 0);
    full_calc("base4", 4);
    run_calc(6, y, lat);
    check("y_wrap", y, 34);
    tick();

    load_f(-128, -128, -128, -128);
    for (int i = 0; i < 8; i++) write_x(i, -128);
    run_calc(0, y, lat);
    check("y_maxneg", y, 65536);
    tick();
    load_f(-1, 0, 0, 0);
    write_x(0, 5);
    run_calc(0, y, lat);
    check("y_sign", y, -5);
    tick();

    load_f(1, 2, 3, 4);
    for (int i = 0; i < 8; i++) write_x(i, i + 1);
    m_ready_y = 1'b0;
    run_calc(0, y, lat);
    check("stall_first_y", y, 30);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        calc_base = 3'd3;
        calc_start = 1'b1;
      end
      tick();
      calc_start = 1'b0;
      check("stall_y", m_data_out_y, 30);
      check("stall_valid_busy", {m_valid_y, calc_busy}, 2'b11);
    end
    m_ready_y = 1'b1;
    tick();
    check("stall_release", {m_valid_y, calc_busy}, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen += m_valid_y + calc_busy;
    end
    check("stall_no_restart", seen, 0);

    clear_f();
    push_f(1); push_f(2);
    calc_start = 1'b1;
    tick();
    calc_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen += m_valid_y + calc_busy;
    end
    check("partial_f_ignored", seen, 0);
    push_f(3); push_f(4);
    check("ready_drop_full", s_ready_f, 0);
    clear_f();
    check("ready_reopen", s_ready_f, 1);

    load_f(1, 2, 3, 4);
    calc_base = 3'd0;
    calc_start = 1'b1;
    tick();
    calc_start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    check("midrst_valid", m_valid_y, 0);
    check("midrst_busy", calc_busy, 0);
    check("midrst_ready", s_ready_f, 0);
    check("midrst_y", m_data_out_y, 0);
    reset = 1'b0;
    tick();
    check("midrst_ready_up", s_ready_f, 1);
    calc_start = 1'b1;
    tick();
    calc_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen += m_valid_y + calc_busy;
    end
    check("midrst_no_calc", seen, 0);

    for (int r = 0; r < 8; r++) begin
      load_f(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
             int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
      for (int i = 0; i < 8; i++) write_x(i, int'($urandom_range(0, 255)) - 128);
      full_calc($sformatf("rand%0d", r), int'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
